score_counter: RTL and testbench
================================

// Module: score_counter
// PURPOSE
//   Game score keeper for the snake core. Counts food-eaten events during a game,
//   tracks game state (idle/playing/over) and saturates at the display limit.
//   Drives the 7-bit score bus that feeds the two-digit 7-segment transcoder,
//   so score is always 0..63.
// PARAMETERS
//   SCORE_MAX   63   saturation / win value; must be <= 63 (transcoder range)
//   POINTS      1    score increment per food event; 1..7
// PORTS
//   clk         in   1  system clock; all logic on rising edge
//   rst_n       in   1  synchronous, active-low reset
//   start       in   1  1-cycle pulse: begin a new game
//   eat         in   1  level from snake logic; high while head overlaps food (may last N cycles)
//   game_over   in   1  1-cycle pulse: collision detected
//   score       out  7  current score, 0..SCORE_MAX
//   playing     out  1  1 while in PLAY
//   win         out  1  1 while in OVER and score reached SCORE_MAX
//   high_score  out  7  best final score since reset (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state=IDLE, score=0, playing=0, win=0,
//     high_score=0, eat_q=0. Reset mid-game aborts immediately; no partial update.
//   FSM (state register, one-hot or binary, implementer's choice):
//     IDLE: score held 0. start -> PLAY (score cleared to 0).
//     PLAY: playing=1. game_over -> OVER. Score update reaching SCORE_MAX -> OVER, win=1.
//     OVER: score frozen; eat ignored. start -> PLAY, score=0, win=0.
//   Eat detection: eat_q <= eat every cycle in all states; event = eat & ~eat_q.
//     One event per rising edge regardless of pulse length. Edge in IDLE/OVER discarded.
//   Increment: 8-bit sum = score + POINTS; score <= (sum >= SCORE_MAX) ? SCORE_MAX : sum[6:0].
//     Latency: score updates on the clk edge after the one sampling eat=1, eat_q=0.
//   Simultaneous events in PLAY (same cycle):
//     eat edge + game_over: increment applied, then OVER (final score includes the food).
//     start in PLAY: ignored.
//     start + game_over in OVER/IDLE: start wins.
//   win is set only by reaching SCORE_MAX, never by game_over alone.
//     If the increment saturates and game_over fires in the same cycle, win=1.
//   Outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   HIGH_SCORE_EN defined: high_score register. On every PLAY->OVER transition,
//     if final score > high_score then high_score <= final score (same edge as the
//     transition). Persists across games; cleared only by rst_n.
//   HIGH_SCORE_EN undefined: high_score tied to 7'd0; no register inferred.
// TESTING
//   1 rst_n=0 2 cycles, release -> score=0, playing=0, win=0, high_score=0.
//   2 start, then eat high 5 cycles, low 3, high 1 -> score=2 (POINTS=1),
//     each step one cycle after the rising edge.
//   3 start, 63 eat edges -> score=63, playing=0, win=1; further eat edges -> score stays 63.
//   4 start, 4 eats, eat edge + game_over same cycle -> score=5, OVER, win=0;
//     HIGH_SCORE_EN: high_score=5. Second game ends at 3 -> high_score stays 5.
//   5 eat edges in IDLE and in OVER -> score unchanged; start in OVER -> score=0, playing=1.
//   6 rst_n=0 mid-game at score=10 -> next edge score=0, IDLE, high_score=0;
//     POINTS=4, SCORE_MAX=63 from score=60 -> score=63, win=1.

Source files
------------

// File: rtl/score_counter.sv
// score_counter
//   Score keeper for the snake game core. Counts food-eaten events while a
//   game is running, tracks the game state (idle / playing / over) and
//   saturates at SCORE_MAX, which is also the winning score. The score bus
//   feeds a two-digit 7-segment transcoder, so SCORE_MAX must stay <= 63.
//
//   Parameters:
//     SCORE_MAX   saturation / win value (<= 63)
//     POINTS      score increment per food event (1..7)
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst_n       in   synchronous active-low reset
//     start       in   1-cycle pulse, begin a new game (ignored while playing)
//     eat         in   level, high while the snake head overlaps food
//     game_over   in   1-cycle pulse, collision detected
//     score       out  current score, 0..SCORE_MAX
//     playing     out  high while a game is running
//     win         out  high in the over state when SCORE_MAX was reached
//     high_score  out  best final score since reset
//
//   Configuration macro: HIGH_SCORE_EN
//     defined   -> high_score register, updated on each play->over transition
//     undefined -> high_score is constant zero
module score_counter #(
  parameter int unsigned SCORE_MAX = 63,
  parameter int unsigned POINTS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       eat,
  input  logic       game_over,
  output logic [6:0] score,
  output logic       playing,
  output logic       win,
  output logic [6:0] high_score
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_score;
  logic       r_win;
  logic       r_eat_q;

  logic       w_eat_evt;
  logic [7:0] w_sum;
  logic [6:0] w_inc;
  logic [6:0] w_play_score;
  logic       w_hit_max;

  // One event per rising edge of eat, however long the level is held.
  assign w_eat_evt = eat & ~r_eat_q;

  // 8-bit sum so a large POINTS near the top cannot wrap before saturation.
  assign w_sum        = {1'b0, r_score} + 8'(POINTS);
  assign w_inc        = (w_sum >= 8'(SCORE_MAX)) ? 7'(SCORE_MAX) : w_sum[6:0];
  assign w_play_score = w_eat_evt ? w_inc : r_score;
  assign w_hit_max    = w_eat_evt && (w_inc == 7'(SCORE_MAX));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_PLAY;
      S_PLAY: if (w_hit_max || game_over) w_next = S_OVER;
      S_OVER: if (start) w_next = S_PLAY;
      default: w_next = S_IDLE;
    endcase
  end

  // Score, win flag and eat edge history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_score <= '0;
      r_win   <= 1'b0;
      r_eat_q <= 1'b0;
    end else begin
      r_eat_q <= eat;
      case (r_state)
        S_IDLE: begin
          r_score <= '0;
          r_win   <= 1'b0;
        end
        S_PLAY: begin
          // The food eaten on the collision cycle still counts, and a
          // saturating increment wins even if game_over fires with it.
          r_score <= w_play_score;
          if (w_hit_max) r_win <= 1'b1;
        end
        S_OVER: begin
          if (start) begin
            r_score <= '0;
            r_win   <= 1'b0;
          end
        end
        default: begin
          r_score <= '0;
          r_win   <= 1'b0;
        end
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  logic [6:0] r_high;
  logic       w_end_game;

  // The final score is the value being written on the same edge as the
  // play->over transition, so compare against the incoming score.
  assign w_end_game = (r_state == S_PLAY) && (w_next == S_OVER);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_high <= '0;
    end else if (w_end_game && (w_play_score > r_high)) begin
      r_high <= w_play_score;
    end
  end
`else
  logic [6:0] r_high;
  assign r_high = '0;
`endif

  // Output logic: all outputs come from registers only.
  always_comb begin
    score      = r_score;
    playing    = (r_state == S_PLAY);
    win        = r_win;
    high_score = r_high;
  end

endmodule

// File: tb/tb_score_counter.sv
module tb_score_counter;

`ifdef HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  localparam int MAXS = 63;

  logic       clk = 1'b0;
  logic       rst_n, start, eat, game_over;
  logic [6:0] score_a, high_a, score_b, high_b;
  logic       playing_a, win_a, playing_b, win_b;

  always #5 clk = ~clk;

  score_counter #(.SCORE_MAX(63), .POINTS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .eat(eat), .game_over(game_over),
    .score(score_a), .playing(playing_a), .win(win_a), .high_score(high_a)
  );

  score_counter #(.SCORE_MAX(63), .POINTS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .eat(eat), .game_over(game_over),
    .score(score_b), .playing(playing_b), .win(win_b), .high_score(high_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, one slot per DUT: game phase as a string-like code
  // ("idle"/"play"/"over"), score as a plain integer.
  int  m_pts[2] = '{1, 4};
  int  m_phase[2];   // 0 idle, 1 play, 2 over
  int  m_score[2];
  int  m_win[2];
  int  m_hs[2];
  int  m_prev_eat[2];

  task automatic model_step(input int k, input bit rn, input bit st,
                            input bit e, input bit go);
    bit food;
    int fin;
    if (!rn) begin
      m_phase[k] = 0; m_score[k] = 0; m_win[k] = 0; m_hs[k] = 0;
      m_prev_eat[k] = 0;
      return;
    end
    food = e && (m_prev_eat[k] == 0);
    m_prev_eat[k] = e;
    if (m_phase[k] == 1) begin
      fin = m_score[k];
      if (food) fin = (fin + m_pts[k] > MAXS) ? MAXS : fin + m_pts[k];
      m_score[k] = fin;
      if (fin == MAXS) m_win[k] = 1;
      if (fin == MAXS || go) begin
        m_phase[k] = 2;
        if (HS_EN && fin > m_hs[k]) m_hs[k] = fin;
      end
    end else if (st) begin
      m_phase[k] = 1; m_score[k] = 0; m_win[k] = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the models, compare both DUTs.
  task automatic cycle(input bit rn, input bit st, input bit e, input bit go);
    rst_n = rn; start = st; eat = e; game_over = go;
    @(posedge clk);
    model_step(0, rn, st, e, go);
    model_step(1, rn, st, e, go);
    #1;
    chk("a.score",   int'(score_a),   m_score[0]);
    chk("a.playing", int'(playing_a), int'(m_phase[0] == 1));
    chk("a.win",     int'(win_a),     m_win[0]);
    chk("a.high",    int'(high_a),    m_hs[0]);
    chk("b.score",   int'(score_b),   m_score[1]);
    chk("b.playing", int'(playing_b), int'(m_phase[1] == 1));
    chk("b.win",     int'(win_b),     m_win[1]);
    chk("b.high",    int'(high_b),    m_hs[1]);
  endtask

  typedef struct {
    bit rn, st, e, go;
    int score, play, win, hs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rn, input bit st, input bit e, input bit go,
                     input int sc, input int pl, input int wn, input int hs);
    vec_t v;
    v.rn = rn; v.st = st; v.e = e; v.go = go;
    v.score = sc; v.play = pl; v.win = wn; v.hs = hs;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; eat = 1'b0; game_over = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_score[k] = 0; m_win[k] = 0; m_hs[k] = 0; m_prev_eat[k] = 0;
    end

    // Reset, eat in idle, start, long/short eat pulses.
    add(0,0,0,0, 0,0,0,0); add(0,0,0,0, 0,0,0,0);
    add(1,0,1,0, 0,0,0,0); add(1,0,0,0, 0,0,0,0);
    add(1,1,0,0, 0,1,0,0);
    for (int i = 0; i < 5; i++) add(1,0,1,0, 1,1,0,0);
    for (int i = 0; i < 3; i++) add(1,0,0,0, 1,1,0,0);
    add(1,0,1,0, 2,1,0,0); add(1,0,0,0, 2,1,0,0);
    // start+game_over while playing: start ignored, game ends at 2.
    add(1,1,0,1, 2,0,0,2);
    // start+game_over while over: start wins.
    add(1,1,0,1, 0,1,0,2);
    for (int i = 1; i <= 4; i++) begin
      add(1,0,1,0, i,1,0,2); add(1,0,0,0, i,1,0,2);
    end
    // Eat edge together with game_over: food counts, no win.
    add(1,0,1,1, 5,0,0,5); add(1,0,0,0, 5,0,0,5);
    add(1,0,1,0, 5,0,0,5);
    add(1,1,0,0, 0,1,0,5);
    for (int i = 1; i <= 3; i++) begin
      add(1,0,1,0, i,1,0,5); add(1,0,0,0, i,1,0,5);
    end
    add(1,0,0,1, 3,0,0,5);

    foreach (vecs[i]) begin
      cycle(vecs[i].rn, vecs[i].st, vecs[i].e, vecs[i].go);
      chk($sformatf("vec%0d.score", i), int'(score_a), vecs[i].score);
      chk($sformatf("vec%0d.playing", i), int'(playing_a), vecs[i].play);
      chk($sformatf("vec%0d.win", i), int'(win_a), vecs[i].win);
      chk($sformatf("vec%0d.high", i), int'(high_a), HS_EN ? vecs[i].hs : 0);
    end

    // Saturation run: 63 food events on POINTS=1, 16 on POINTS=4.
    cycle(0,0,0,0); cycle(0,0,0,0);
    cycle(1,1,0,0);
    for (int k = 1; k <= 63; k++) begin
      cycle(1,0,1,0);
      if (k == 15) chk("p4.score60", int'(score_b), 60);
      if (k == 16) begin
        chk("p4.score_sat", int'(score_b), 63);
        chk("p4.win", int'(win_b), 1);
        chk("p4.playing", int'(playing_b), 0);
      end
      cycle(1,0,0,0);
    end
    chk("sat.score", int'(score_a), 63);
    chk("sat.playing", int'(playing_a), 0);
    chk("sat.win", int'(win_a), 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1,0,1,0); cycle(1,0,0,0);
    end
    chk("sat.hold", int'(score_a), 63);

    // Reset in the middle of a game.
    cycle(1,1,0,0);
    chk("restart.score", int'(score_a), 0);
    chk("restart.win", int'(win_a), 0);
    for (int k = 0; k < 10; k++) begin
      cycle(1,0,1,0); cycle(1,0,0,0);
    end
    chk("mid.score10", int'(score_a), 10);
    cycle(0,0,1,0);
    chk("midrst.score", int'(score_a), 0);
    chk("midrst.playing", int'(playing_a), 0);
    chk("midrst.high", int'(high_a), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) >= 2),
            ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
